// File: rtl/vga_stream_decoder.sv
// vga_stream_decoder: recovers pixel position, colour and frame lock from a TinyVGA pmod stream
// Ports: clk/reset (sync, active-high); pmod_in {hsync,B0,G0,R0,vsync,B1,G1,R1};
//        x/y recovered position, r/g/b colour, pix_valid, locked, frame_start pulse, frame_count.
module vga_stream_decoder #(
  parameter int H_DISPLAY  = 640,
  parameter int H_TOTAL    = 800,
  parameter int H_SYNC_X   = 656,
  parameter int V_DISPLAY  = 480,
  parameter int V_TOTAL    = 525,
  parameter int V_SYNC_Y   = 490,
  parameter bit SYNC_POL   = 1'b0,
  parameter int LOCK_LINES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pmod_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       pix_valid,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] frame_count
);
  localparam int WDW = $clog2(2 * H_TOTAL + 1);
  localparam int GLW = $clog2(LOCK_LINES + 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSX = 10'(H_SYNC_X);
  localparam logic [9:0] VSY = 10'(V_SYNC_Y);
  localparam logic [9:0] HD = 10'(H_DISPLAY);
  localparam logic [9:0] VD = 10'(V_DISPLAY);
  localparam logic [WDW-1:0] WD_MAX = WDW'(2 * H_TOTAL);
  localparam logic [GLW-1:0] GL_MAX = GLW'(LOCK_LINES);
  typedef enum logic [1:0] {SEARCH, H_LOCK, LOCKED} state_t;
  state_t state_q, state_d;
  logic [7:0] s1_q, fc_q;
  logic hs_p_q, vs_p_q;
  logic [9:0] h_q, h_d, v_q, v_d, x_q, y_q;
  logic [GLW-1:0] good_q, good_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic pv_q, pv_d, fs_q, fs_d;
  logic hs_edge, vs_edge, hs_bad, vs_good, vs_bad, wrap, wd_exp;
  // h_q/v_q always describe the pixel currently held in s1_q
  always_comb begin
    hs_edge = s1_q[7] == SYNC_POL && hs_p_q != SYNC_POL;
    vs_edge = s1_q[3] == SYNC_POL && vs_p_q != SYNC_POL;
    hs_bad = hs_edge && h_q != HSX;
    vs_good = vs_edge && v_q == VSY;
    vs_bad = vs_edge && v_q != VSY;
    wrap = !hs_edge && h_q == H_LAST;
    wd_exp = wd_q == WD_MAX;
    h_d = hs_edge ? HSX + 10'd1 : wrap ? 10'd0 : h_q + 10'd1;
    // a vsync edge pins the current line to VSY; the wrap decision already includes any hsync reload
    v_d = vs_edge ? VSY + {9'd0, wrap} : !wrap ? v_q : v_q == V_LAST ? 10'd0 : v_q + 10'd1;
    wd_d = hs_edge || wd_exp ? '0 : wd_q + 1'b1;
    good_d = hs_bad || wd_exp ? '0 : hs_edge && good_q != GL_MAX ? good_q + 1'b1 : good_q;
    state_d = state_q;
    case (state_q)
      SEARCH:  state_d = good_q == GL_MAX && !hs_bad ? H_LOCK : SEARCH;
      H_LOCK:  state_d = hs_bad ? SEARCH : vs_good ? LOCKED : H_LOCK;
      LOCKED:  state_d = hs_bad ? SEARCH : vs_bad ? H_LOCK : LOCKED;
      default: state_d = SEARCH;
    endcase
    if (wd_exp) state_d = SEARCH;
    pv_d = state_q == LOCKED && h_q < HD && v_q < VD;
    fs_d = state_q == LOCKED && h_q == 10'd0 && v_q == 10'd0;
    r_d = pv_d ? {s1_q[0], s1_q[4]} : 2'd0;
    g_d = pv_d ? {s1_q[1], s1_q[5]} : 2'd0;
    b_d = pv_d ? {s1_q[2], s1_q[6]} : 2'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      s1_q <= '0;
      hs_p_q <= 1'b0;
      vs_p_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
      good_q <= '0;
      wd_q <= '0;
      x_q <= '0;
      y_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      pv_q <= 1'b0;
      fs_q <= 1'b0;
      fc_q <= '0;
    end else begin
      state_q <= state_d;
      s1_q <= pmod_in;
      hs_p_q <= s1_q[7];
      vs_p_q <= s1_q[3];
      h_q <= h_d;
      v_q <= v_d;
      good_q <= good_d;
      wd_q <= wd_d;
      x_q <= h_q;
      y_q <= v_q;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      pv_q <= pv_d;
      fs_q <= fs_d;
      fc_q <= fc_q + {7'd0, fs_d};
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
  assign pix_valid = pv_q;
  assign locked = state_q == LOCKED;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
endmodule

// File: tb/tb_vga_stream_decoder.sv
// tb_vga_stream_decoder: directed scenario tests on a reduced 20x8 timing (12x5 visible)
module tb_vga_stream_decoder;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] pmod_in = 8'h88;
  logic [9:0] x, y;
  logic [1:0] r, g, b;
  logic pix_valid, locked, frame_start;
  logic [7:0] frame_count;
  int total = 0, bad = 0;
  int gx = 0, gy = 0, lx = 999, ly = 999, ox = 999, oy = 999;
  int vs_line = 6, short_y = 99;
  bit hs_kill = 1'b0;

  vga_stream_decoder #(.H_DISPLAY(12), .H_TOTAL(20), .H_SYNC_X(14), .V_DISPLAY(5), .V_TOTAL(8),
                       .V_SYNC_Y(6), .SYNC_POL(1'b0), .LOCK_LINES(4)) dut (
    .clk(clk), .reset(reset), .pmod_in(pmod_in), .x(x), .y(y), .r(r), .g(g), .b(b),
    .pix_valid(pix_valid), .locked(locked), .frame_start(frame_start), .frame_count(frame_count));

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int px, input int py);
    logic [1:0] cr, cg, cb;
    logic hs, vs;
    cr = 2'(px % 4);
    cg = 2'((py + 1) % 4);
    cb = 2'((px + py + 1) % 4);
    hs = !((px == 14 || px == 15) && !hs_kill);
    vs = py != vs_line;
    return {hs, cb[0], cg[0], cr[0], vs, cb[1], cg[1], cr[1]};
  endfunction

  // after each step, ox/oy name the source pixel whose decode is on the outputs
  task automatic step();
    pmod_in = enc(gx, gy);
    @(posedge clk);
    #1;
    ox = lx; oy = ly; lx = gx; ly = gy;
    gx++;
    if (gx == ((gy == short_y) ? 19 : 20)) begin gx = 0; gy = (gy + 1) % 8; end
  endtask

  task automatic wait_pix(input int wx, input int wy);
    for (int i = 0; i < 400; i++) begin
      step();
      if (ox == wx && oy == wy) return;
    end
    total++; bad++;
    $display("FAIL wait_pix: pixel (%0d,%0d) not reached within 400 cycles", wx, wy);
  endtask

  task automatic reset_on();
    reset = 1'b1; pmod_in = 8'h88;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_off();
    reset = 1'b0; gx = 0; gy = 0; lx = 999; ly = 999; ox = 999; oy = 999;
  endtask

  task automatic test_reset();
    reset_on();
    reset_on();
    total++;
    if ({x, y, r, g, b, pix_valid, locked, frame_start, frame_count} !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d rgb=%0d/%0d/%0d pv=%b lk=%b fs=%b fc=%0d want all 0",
               x, y, r, g, b, pix_valid, locked, frame_start, frame_count);
    end
    reset_off();
  endtask

  task automatic test_lock();
    wait_pix(19, 5);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_before_vsync: got %b want 0", locked); end
    wait_pix(0, 6);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_after_vsync: got %b want 1", locked); end
    wait_pix(0, 0);
    total++;
    if ({frame_start, x, y} !== {1'b1, 10'd0, 10'd0}) begin
      bad++; $display("FAIL frame_start_pos: got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", frame_start, x, y);
    end
    total++;
    if ({pix_valid, r, g, b} !== {1'b1, 2'd0, 2'd1, 2'd1}) begin
      bad++; $display("FAIL first_pixel: got pv=%b rgb=%0d/%0d/%0d want pv=1 rgb=0/1/1", pix_valid, r, g, b);
    end
    total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL frame_count_1: got %0d want 1", frame_count); end
    wait_pix(1, 0);
    total++;
    if ({frame_start, x, r, g, b} !== {1'b0, 10'd1, 2'd1, 2'd1, 2'd2}) begin
      bad++; $display("FAIL second_pixel: got fs=%b x=%0d rgb=%0d/%0d/%0d want fs=0 x=1 rgb=1/1/2",
                      frame_start, x, r, g, b);
    end
  endtask

  task automatic test_pixels();
    wait_pix(5, 2);
    total++;
    if ({pix_valid, x, y, r, g, b} !== {1'b1, 10'd5, 10'd2, 2'd1, 2'd3, 2'd0}) begin
      bad++; $display("FAIL pix_5_2: got pv=%b x=%0d y=%0d rgb=%0d/%0d/%0d want 1 5 2 1/3/0", pix_valid, x, y, r, g, b);
    end
    wait_pix(11, 4);
    total++;
    if ({pix_valid, x, y, r, g, b} !== {1'b1, 10'd11, 10'd4, 2'd3, 2'd1, 2'd0}) begin
      bad++; $display("FAIL pix_last_visible: got pv=%b x=%0d y=%0d rgb=%0d/%0d/%0d want 1 11 4 3/1/0", pix_valid, x, y, r, g, b);
    end
    wait_pix(12, 4);
    total++;
    if ({pix_valid, x, y, r, g, b} !== {1'b0, 10'd12, 10'd4, 2'd0, 2'd0, 2'd0}) begin
      bad++; $display("FAIL pix_h_blank: got pv=%b x=%0d y=%0d rgb=%0d/%0d/%0d want 0 12 4 0/0/0", pix_valid, x, y, r, g, b);
    end
    wait_pix(11, 5);
    total++;
    if ({pix_valid, x, y, r, g, b} !== {1'b0, 10'd11, 10'd5, 2'd0, 2'd0, 2'd0}) begin
      bad++; $display("FAIL pix_v_blank: got pv=%b x=%0d y=%0d rgb=%0d/%0d/%0d want 0 11 5 0/0/0", pix_valid, x, y, r, g, b);
    end
  endtask

  task automatic test_short_line();
    short_y = 2;
    wait_pix(13, 3);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL short_before_edge: got %b want 1", locked); end
    wait_pix(14, 3);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_bad_hsync: got %b want 0", locked); end
    short_y = 99;
    wait_pix(0, 6);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_vsync_while_search: got %b want 0", locked); end
    wait_pix(19, 5);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL short_hlock_wait: got %b want 0", locked); end
    wait_pix(0, 6);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL short_relock: got %b want 1", locked); end
  endtask

  task automatic test_vsync_moved();
    wait_pix(0, 0);
    vs_line = 7;
    wait_pix(19, 6);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL vmove_before: got %b want 1", locked); end
    wait_pix(0, 7);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL vmove_bad_vsync: got %b want 0", locked); end
    vs_line = 6;
    wait_pix(0, 0);
    total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL vmove_no_fs: got %b want 0", frame_start); end
    wait_pix(0, 0);
    wait_pix(0, 0);
    total++;
    if ({locked, frame_start, x, y} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      bad++; $display("FAIL vmove_relock: got lk=%b fs=%b x=%0d y=%0d want 1 1 0 0", locked, frame_start, x, y);
    end
  endtask

  task automatic test_midline_reset();
    wait_pix(6, 2);
    total++;
    if ({locked, pix_valid, x, y} !== {1'b1, 1'b1, 10'd6, 10'd2}) begin
      bad++; $display("FAIL pre_reset: got lk=%b pv=%b x=%0d y=%0d want 1 1 6 2", locked, pix_valid, x, y);
    end
    reset_on();
    total++;
    if ({x, y, r, g, b, pix_valid, locked, frame_start, frame_count} !== 39'd0) begin
      bad++;
      $display("FAIL midline_reset: got x=%0d y=%0d rgb=%0d/%0d/%0d pv=%b lk=%b fs=%b fc=%0d want all 0",
               x, y, r, g, b, pix_valid, locked, frame_start, frame_count);
    end
    reset_off();
  endtask

  task automatic test_frame_wrap();
    for (int k = 0; k <= 256; k++) begin
      wait_pix(0, 0);
      if (k == 0) begin
        total++;
        if ({locked, frame_start, frame_count} !== 10'd0) begin
          bad++; $display("FAIL wrap_f0: got lk=%b fs=%b fc=%0d want 0 0 0", locked, frame_start, frame_count);
        end
      end
      if (k == 1 || k == 255 || k == 256) begin
        total++;
        if ({locked, frame_start, frame_count} !== {1'b1, 1'b1, 8'(k % 256)}) begin
          bad++; $display("FAIL wrap_f%0d: got lk=%b fs=%b fc=%0d want 1 1 %0d", k, locked, frame_start, frame_count, k % 256);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    wait_pix(18, 2);
    hs_kill = 1'b1;
    repeat (30) step();
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL wd_early: got %b want 1", locked); end
    repeat (20) step();
    total++;
    if ({locked, pix_valid} !== 2'b00) begin
      bad++; $display("FAIL wd_fired: got lk=%b pv=%b want 0 0", locked, pix_valid);
    end
    hs_kill = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pixels();
    test_short_line();
    test_vsync_moved();
    test_midline_reset();
    test_frame_wrap();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
